// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU job sequencer: FSM states,
// data-memory address map of the division program and the saturated quotient.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      LOAD,
      RUN,
      READ,
      RESP
   } seq_state_e;

   localparam logic [7:0] DM_DIVD_HI = 8'd0;
   localparam logic [7:0] DM_DIVD_LO = 8'd1;
   localparam logic [7:0] DM_DIVR    = 8'd2;
   localparam logic [7:0] DM_Q_HI    = 8'd4;
   localparam logic [7:0] DM_Q_MID   = 8'd5;
   localparam logic [7:0] DM_Q_LO    = 8'd6;

   localparam logic [23:0] Q_SAT = 24'hFFFFFF;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Cycle counter shared by the sequencer: counts cycles spent in the current
// state; expired_o flags the last allowed RUN cycle.
module seq_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             enable_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expired_o
);

   logic [CNT_W-1:0] count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (enable_i) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count_o   = count_q;
   assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_job_sequencer.sv
// Job front-end for the division program: primes the CPU, loads operands into
// data memory, runs the program with a timeout and returns the 24-bit quotient.
module cpu_job_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int PRIME_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        job_valid_i,
   output logic        job_ready_o,
   input  logic [15:0] job_dividend_i,
   input  logic [7:0]  job_divisor_i,
   output logic        cpu_reset_o,
   output logic        cpu_start_o,
   input  logic        cpu_ack_i,
   output logic        dm_we_o,
   output logic [7:0]  dm_addr_o,
   output logic [7:0]  dm_wdata_o,
   input  logic [7:0]  dm_rdata_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [23:0] res_quotient_o,
   output logic        res_sat_o,
   output logic        res_timeout_o,
   output logic        busy_o
);

   localparam int STEP_MAX = (PRIME_CYCLES > 3) ? PRIME_CYCLES : 3;
   localparam int CNT_MAX  = (TIMEOUT_CYCLES > STEP_MAX) ? TIMEOUT_CYCLES : STEP_MAX;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYCLES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(2);

   seq_state_e  state_q, state_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        cpu_start_q, cpu_start_d;
   logic        dm_we_q, dm_we_d;
   logic [7:0]  dm_addr_q, dm_addr_d;
   logic [7:0]  dm_wdata_q, dm_wdata_d;
   logic        res_valid_q, res_valid_d;
   logic [23:0] quot_q, quot_d;
   logic        sat_q, sat_d;
   logic        timeout_q, timeout_d;
   logic [15:0] divd_q, divd_d;
   logic [7:0]  divr_q, divr_d;

   logic [CNT_W-1:0] count, next_step;
   logic             expired, ctr_clear, ctr_enable;

   assign ctr_clear  = (state_d != state_q);
   assign ctr_enable = (state_q != IDLE) && (state_q != RESP);
   assign next_step  = ctr_clear ? '0 : count + CNT_W'(1);

   seq_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_ctr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clear_i  (ctr_clear),
      .enable_i (ctr_enable),
      .count_o  (count),
      .expired_o(expired)
   );

   always_comb begin
      // NOTE: every _d gets a default first, so no path through this block infers a latch.
      state_d     = state_q;
      divd_d      = divd_q;
      divr_d      = divr_q;
      quot_d      = quot_q;
      sat_d       = sat_q;
      timeout_d   = timeout_q;
      cpu_reset_d = 1'b1;
      cpu_start_d = 1'b1;
      dm_we_d     = 1'b0;
      dm_addr_d   = '0;
      dm_wdata_d  = '0;

      unique case (state_q)
         IDLE: begin
            if (job_valid_i && job_ready_o) begin
               divd_d = job_dividend_i;
               divr_d = job_divisor_i;
               if (job_divisor_i == 8'd0) begin
                  state_d = RESP;
                  quot_d  = Q_SAT;
                  sat_d   = 1'b1;
               end else begin
                  state_d = PRIME;
               end
            end
         end
         PRIME: if (count == PRIME_LAST) state_d = LOAD;
         LOAD:  if (count == STEP_LAST) state_d = RUN;
         RUN: begin
            // ack is checked first so it wins over a coincident final timeout cycle
            if (cpu_ack_i) begin
               state_d = READ;
            end else if (expired) begin
               state_d   = RESP;
               quot_d    = Q_SAT;
               timeout_d = 1'b1;
            end
         end
         READ: begin
            if (count == CNT_W'(0))      quot_d[23:16] = dm_rdata_i;
            else if (count == CNT_W'(1)) quot_d[15:8]  = dm_rdata_i;
            else                         quot_d[7:0]   = dm_rdata_i;
            if (count == STEP_LAST) state_d = RESP;
         end
         RESP: begin
            if (res_ready_i) begin
               state_d   = IDLE;
               sat_d     = 1'b0;
               timeout_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      unique case (state_d)
         LOAD: begin
            cpu_reset_d = 1'b0;
            dm_we_d     = 1'b1;
            if (next_step == CNT_W'(0)) begin
               dm_addr_d  = DM_DIVD_HI;
               dm_wdata_d = divd_d[15:8];
            end else if (next_step == CNT_W'(1)) begin
               dm_addr_d  = DM_DIVD_LO;
               dm_wdata_d = divd_d[7:0];
            end else begin
               dm_addr_d  = DM_DIVR;
               dm_wdata_d = divr_d;
            end
         end
         RUN: begin
            cpu_reset_d = 1'b0;
            cpu_start_d = 1'b0;
         end
         READ: begin
            cpu_reset_d = 1'b0;
            cpu_start_d = 1'b0;
            if (next_step == CNT_W'(0))      dm_addr_d = DM_Q_HI;
            else if (next_step == CNT_W'(1)) dm_addr_d = DM_Q_MID;
            else                             dm_addr_d = DM_Q_LO;
         end
         default: ;
      endcase

      res_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cpu_reset_q <= 1'b1;
         cpu_start_q <= 1'b1;
         dm_we_q     <= 1'b0;
         dm_addr_q   <= '0;
         dm_wdata_q  <= '0;
         res_valid_q <= 1'b0;
         quot_q      <= '0;
         sat_q       <= 1'b0;
         timeout_q   <= 1'b0;
         divd_q      <= '0;
         divr_q      <= '0;
      end else begin
         state_q     <= state_d;
         cpu_reset_q <= cpu_reset_d;
         cpu_start_q <= cpu_start_d;
         dm_we_q     <= dm_we_d;
         dm_addr_q   <= dm_addr_d;
         dm_wdata_q  <= dm_wdata_d;
         res_valid_q <= res_valid_d;
         quot_q      <= quot_d;
         sat_q       <= sat_d;
         timeout_q   <= timeout_d;
         divd_q      <= divd_d;
         divr_q      <= divr_d;
      end
   end

   assign job_ready_o    = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign cpu_reset_o    = cpu_reset_q;
   assign cpu_start_o    = cpu_start_q;
   assign dm_we_o        = dm_we_q;
   assign dm_addr_o      = dm_addr_q;
   assign dm_wdata_o     = dm_wdata_q;
   assign res_valid_o    = res_valid_q;
   assign res_quotient_o = quot_q;
   assign res_sat_o      = sat_q;
   assign res_timeout_o  = timeout_q;

endmodule

// File: tb/tb_cpu_job_sequencer.sv
// Bench for cpu_job_sequencer with a behavioural data memory and a CPU model
// that computes (dividend<<16)/divisor a few cycles after cpu_start falls.
module tb_cpu_job_sequencer;

   localparam int PRIME_CYCLES   = 2;
   localparam int TIMEOUT_CYCLES = 20;
   localparam int ACK_DELAY      = 3;
   // accept cycle + prime + load + run (ack delay + 2) + read
   localparam int LAT_OK = 1 + PRIME_CYCLES + 3 + (ACK_DELAY + 2) + 3;
   localparam int LAT_TO = 1 + PRIME_CYCLES + 3 + TIMEOUT_CYCLES;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid, job_ready;
   logic [15:0] job_dividend;
   logic [7:0]  job_divisor;
   logic        cpu_reset, cpu_start, cpu_ack;
   logic        dm_we;
   logic [7:0]  dm_addr, dm_wdata, dm_rdata;
   logic        res_valid, res_ready;
   logic [23:0] res_quotient;
   logic        res_sat, res_timeout, busy;

   int n_checks = 0;
   int n_errors = 0;

   cpu_job_sequencer #(
      .PRIME_CYCLES  (PRIME_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .job_valid_i   (job_valid),
      .job_ready_o   (job_ready),
      .job_dividend_i(job_dividend),
      .job_divisor_i (job_divisor),
      .cpu_reset_o   (cpu_reset),
      .cpu_start_o   (cpu_start),
      .cpu_ack_i     (cpu_ack),
      .dm_we_o       (dm_we),
      .dm_addr_o     (dm_addr),
      .dm_wdata_o    (dm_wdata),
      .dm_rdata_i    (dm_rdata),
      .res_valid_o   (res_valid),
      .res_ready_i   (res_ready),
      .res_quotient_o(res_quotient),
      .res_sat_o     (res_sat),
      .res_timeout_o (res_timeout),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   // Behavioural data memory and CPU model
   logic [7:0]  dm [0:255];
   logic [7:0]  wlog_a [0:63];
   logic [7:0]  wlog_d [0:63];
   int          wr_total = 0;
   logic        model_ack = 1'b0;
   int          run_cnt = 0;
   int          ack_delay = ACK_DELAY;
   logic        ack_mute = 1'b0;
   logic        force_ack = 1'b0;
   logic [23:0] model_q;

   function automatic logic [23:0] div_q(input logic [7:0] hi, input logic [7:0] lo,
                                         input logic [7:0] d);
      logic [31:0] t;
      t = (d == 8'd0) ? 32'hFFFFFFFF : ({hi, lo, 16'h0000} / {24'h0, d});
      return t[23:0];
   endfunction

   assign model_q  = div_q(dm[0], dm[1], dm[2]);
   assign dm_rdata = dm[dm_addr];
   assign cpu_ack  = model_ack | force_ack;

   always @(posedge clk) begin
      if (dm_we) begin
         dm[dm_addr] <= dm_wdata;
         wlog_a[wr_total % 64] <= dm_addr;
         wlog_d[wr_total % 64] <= dm_wdata;
         wr_total <= wr_total + 1;
      end
      if (cpu_reset) begin
         model_ack <= 1'b0;
         run_cnt   <= 0;
      end else if (!cpu_start && !ack_mute) begin
         run_cnt <= run_cnt + 1;
         if (run_cnt == ack_delay) begin
            dm[4]     <= model_q[23:16];
            dm[5]     <= model_q[15:8];
            dm[6]     <= model_q[7:0];
            model_ack <= 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic offer_job(input logic [15:0] a, input logic [7:0] b);
      int n;
      n = 0;
      job_dividend = a;
      job_divisor  = b;
      job_valid    = 1'b1;
      while (!job_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("job_ready wait", job_ready, 1);
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge; lat counts from the accept cycle.
   task automatic wait_result(output int lat, output int rdy_hi, output int st_lo);
      lat = 1; rdy_hi = 0; st_lo = 0;
      while (1) begin
         if (job_ready) rdy_hi++;
         if (!cpu_start) st_lo++;
         if (res_valid || lat >= 300) break;
         @(negedge clk);
         lat++;
      end
      check("res_valid wait", res_valid, 1);
   endtask

   task automatic handshake(input string name);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({name, " res_valid cleared"}, res_valid, 0);
      check({name, " flags cleared"}, {res_sat, res_timeout}, 0);
      check({name, " idle"}, busy, 0);
   endtask

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [23:0] q;
      logic        sat;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[6];

   task automatic set_vec(input int i, input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [23:0] q, input logic sat, input int lat,
                          input string name);
      vecs[i].dvd = dvd; vecs[i].dvs = dvs; vecs[i].q = q;
      vecs[i].sat = sat; vecs[i].lat = lat; vecs[i].name = name;
   endtask

   task automatic run_job(input vec_t v);
      int lat, rdy_hi, st_lo, w0;
      logic [7:0] exp_d [3];
      w0 = wr_total;
      exp_d[0] = v.dvd[15:8];
      exp_d[1] = v.dvd[7:0];
      exp_d[2] = v.dvs;
      offer_job(v.dvd, v.dvs);
      wait_result(lat, rdy_hi, st_lo);
      check({v.name, " latency"}, lat, v.lat);
      check({v.name, " quotient"}, res_quotient, v.q);
      check({v.name, " sat"}, res_sat, v.sat);
      check({v.name, " timeout"}, res_timeout, 0);
      check({v.name, " job_ready low while busy"}, rdy_hi, 0);
      if (v.sat) begin
         check({v.name, " cpu_start stayed high"}, st_lo, 0);
         check({v.name, " no dm writes"}, wr_total - w0, 0);
      end else begin
         check({v.name, " dm write count"}, wr_total - w0, 3);
         for (int k = 0; k < 3; k++) begin
            check({v.name, " dm write addr"}, wlog_a[(w0 + k) % 64], k);
            check({v.name, " dm write data"}, wlog_d[(w0 + k) % 64], exp_d[k]);
         end
      end
      handshake(v.name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat, rdy_hi, st_lo, n;

      set_vec(0, 16'd90,   8'd5,   24'h120000, 1'b0, LAT_OK, "90/5");
      set_vec(1, 16'd255,  8'd255, 24'h010000, 1'b0, LAT_OK, "255/255");
      set_vec(2, 16'd1000, 8'd7,   24'h8EDB6D, 1'b0, LAT_OK, "1000/7");
      set_vec(3, 16'd1,    8'd255, 24'h000101, 1'b0, LAT_OK, "1/255");
      set_vec(4, 16'd17,   8'd0,   24'hFFFFFF, 1'b1, 1,      "17/0");
      set_vec(5, 16'd0,    8'd9,   24'h000000, 1'b0, LAT_OK, "0/9");

      reset = 1'b1; job_valid = 1'b0; job_dividend = '0; job_divisor = '0; res_ready = 1'b0;
      #22;
      check("reset cpu_reset", cpu_reset, 1);
      check("reset cpu_start", cpu_start, 1);
      check("reset dm bus", {dm_we, dm_addr, dm_wdata}, 0);
      check("reset result", {res_valid, res_quotient, res_sat, res_timeout}, 0);
      check("reset busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("job_ready after reset", job_ready, 1);

      for (int i = 0; i < 6; i++) run_job(vecs[i]);

      // Back-to-back: second job held on the port while the first is in flight
      offer_job(16'd270, 8'd14);
      job_dividend = 16'd3; job_divisor = 8'd116; job_valid = 1'b1;
      wait_result(lat, rdy_hi, st_lo);
      check("b2b first quotient", res_quotient, 24'h134924);
      check("b2b job_ready low", rdy_hi, 0);
      handshake("b2b first");
      check("b2b job_ready back", job_ready, 1);
      offer_job(16'd3, 8'd116);
      wait_result(lat, rdy_hi, st_lo);
      check("b2b second latency", lat, LAT_OK);
      check("b2b second quotient", res_quotient, 24'h00069E);
      handshake("b2b second");

      // Timeout: CPU never acks
      ack_mute = 1'b1;
      offer_job(16'd200, 8'd3);
      wait_result(lat, rdy_hi, st_lo);
      check("timeout latency", lat, LAT_TO);
      check("timeout flag", res_timeout, 1);
      check("timeout sat", res_sat, 0);
      check("timeout quotient", res_quotient, 24'hFFFFFF);
      check("timeout cpu_reset", cpu_reset, 1);
      handshake("timeout");
      ack_mute = 1'b0;

      // Ack during LOAD ignored; result held while res_ready stays low
      offer_job(16'd270, 8'd14);
      n = 0;
      while (!dm_we && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("load seen", dm_we, 1);
      force_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      force_ack = 1'b0;
      wait_result(lat, rdy_hi, st_lo);
      check("load-ack quotient", res_quotient, 24'h134924);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold res_valid", res_valid, 1);
         check("hold quotient", res_quotient, 24'h134924);
      end
      handshake("hold");

      // Reset pulsed in RUN
      ack_delay = 10;
      offer_job(16'd90, 8'd5);
      n = 0;
      while (cpu_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("run reached", cpu_start, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid-run reset cpu_reset", cpu_reset, 1);
      check("mid-run reset cpu_start", cpu_start, 1);
      check("mid-run reset dm bus", {dm_we, dm_addr, dm_wdata}, 0);
      check("mid-run reset result", {res_valid, res_quotient, res_sat, res_timeout}, 0);
      check("mid-run reset busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      ack_delay = ACK_DELAY;
      @(negedge clk);
      check("post-reset res_valid", res_valid, 0);
      run_job(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
